// File: rtl/regfile_dump_controller_pkg.sv
// Shared debug package: dump FSM state encoding and word/byte sizing constants
// used by the register-file dump controller and its byte serializer.
package regfile_dump_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_ADDR = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_SEND     = 3'd3,
    ST_DONE     = 3'd4
  } dump_state_e;

  localparam int NB_DEFAULT      = 32;
  localparam int NB_BYTE_DEFAULT = 8;
  localparam int BYTES_PER_WORD  = NB_DEFAULT / NB_BYTE_DEFAULT;

  // Counter width for n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_controller_serializer.sv
// Word buffer plus byte-at-a-time valid/ready transmitter, least-significant
// byte first. A load snapshots the word so later register writes cannot leak in.
import regfile_dump_controller_pkg::*;

module word_byte_serializer #(
  parameter int NB      = NB_DEFAULT,
  parameter int NB_BYTE = NB_BYTE_DEFAULT,
  parameter int BPW     = BYTES_PER_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [NB-1:0]      i_word,
  input  logic               i_ready,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_valid,
  output logic               o_accept,
  output logic               o_last
);

  localparam int IDX_W = idx_width(BPW);

  logic [NB-1:0]      word_q, word_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [NB_BYTE-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  assign o_accept = valid_q & i_ready;
  assign o_last   = (byte_idx_q == IDX_W'(BPW - 1));
  assign o_data   = data_q;
  assign o_valid  = valid_q;

  // The outgoing byte is registered so it cannot glitch while the sink stalls.
  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    valid_d    = valid_q;
    data_d     = data_q;
    if (i_load) begin
      word_d     = i_word;
      byte_idx_d = '0;
      valid_d    = 1'b1;
      data_d     = i_word[NB_BYTE-1:0];
    end else if (o_accept) begin
      if (o_last) begin
        valid_d = 1'b0;
      end else begin
        byte_idx_d = byte_idx_q + IDX_W'(1);
        data_d     = word_q[int'(byte_idx_d) * NB_BYTE +: NB_BYTE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q     <= '0;
      byte_idx_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: rtl/regfile_dump_controller.sv
// Streams the first N_DUMP registers of a halted CPU out over a byte-wide
// valid/ready link, one address-settle and one capture cycle per register.
import regfile_dump_controller_pkg::*;

module regfile_dump_controller #(
  parameter int NB      = 32,
  parameter int REGS    = 5,
  parameter int NB_BYTE = 8,
  parameter int N_DUMP  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_cpu_halted,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic               i_tx_ready,
  output logic [REGS-1:0]    o_mips_register_number,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int              BPW      = NB / NB_BYTE;
  localparam logic [REGS-1:0] LAST_REG = REGS'(N_DUMP - 1);

  dump_state_e     state_q, state_d;
  logic [REGS-1:0] reg_idx_q, reg_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ser_load;
  logic            ser_accept;
  logic            ser_last;

  assign ser_load               = (state_q == ST_CAPTURE);
  assign o_mips_register_number = reg_idx_q;
  assign o_busy                 = busy_q;
  assign o_done                 = done_q;

  word_byte_serializer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE),
    .BPW     (BPW)
  ) u_serializer (
    .clk      (i_clk),
    .rst      (i_reset),
    .i_load   (ser_load),
    .i_word   (i_mips_register_data),
    .i_ready  (i_tx_ready),
    .o_data   (o_tx_data),
    .o_valid  (o_tx_valid),
    .o_accept (ser_accept),
    .o_last   (ser_last)
  );

  // busy/done are derived from the next state so they line up with the state flops.
  always_comb begin
    state_d   = state_q;
    reg_idx_d = reg_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && i_cpu_halted) begin
          reg_idx_d = '0;
          state_d   = ST_SET_ADDR;
        end
      end
      ST_SET_ADDR: state_d = ST_CAPTURE;
      ST_CAPTURE:  state_d = ST_SEND;
      ST_SEND: begin
        if (ser_accept && ser_last) begin
          if (reg_idx_q == LAST_REG) begin
            state_d = ST_DONE;
          end else begin
            reg_idx_d = reg_idx_q + REGS'(1);
            state_d   = ST_SET_ADDR;
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        reg_idx_d = '0;
      end
      default: begin
        state_d   = ST_IDLE;
        reg_idx_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      reg_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_idx_q <= reg_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Self-checking bench for regfile_dump_controller: a per-cycle vector table for
// the start-up handshake, then full dumps covering stalls, restarts and resets.
module tb_regfile_dump_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halted;
  logic        ready;
  logic [31:0] rf [32];
  logic [31:0] reg_data;
  logic [4:0]  reg_num;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  // Combinational register file debug read port.
  assign reg_data = rf[reg_num];

  regfile_dump_controller #(
    .NB      (32),
    .REGS    (5),
    .NB_BYTE (8),
    .N_DUMP  (32)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .i_start                (start),
    .i_cpu_halted           (halted),
    .i_mips_register_data   (reg_data),
    .i_tx_ready             (ready),
    .o_mips_register_number (reg_num),
    .o_tx_data              (tx_data),
    .o_tx_valid             (tx_valid),
    .o_busy                 (busy),
    .o_done                 (done)
  );

  typedef struct {
    logic       start;
    logic       halted;
    logic       ready;
    logic       expBusy;
    logic       expValid;
    logic       expDone;
    logic [4:0] expReg;
    logic       chkData;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic r);
    start  = s;
    halted = h;
    ready  = r;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " reg_num"}, 32'(reg_num), 32'd0);
    checkOutput({tag, " tx_data"}, 32'(tx_data), 32'd0);
    checkOutput({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
  endtask

  // mode 0: plain, 1: ready toggling, 2: start re-pulsed in R5 SEND, 3: R3 rewritten after capture
  task automatic runDump(input int mode);
    logic [7:0]  expBytes [128];
    logic [31:0] w;
    logic [31:0] savedR3;
    logic [7:0]  lastData;
    bit          lastStall;
    int          e;
    int          nb;
    int          doneSeen;
    int          doneEdge;
    int          stalls;
    string       tag;
    tag = $sformatf("dump%0d", mode);
    for (int r = 0; r < 32; r++) begin
      w = rf[r];
      for (int b = 0; b < 4; b++) expBytes[r*4 + b] = w[8*b +: 8];
    end
    savedR3   = rf[3];
    nb        = 0;
    doneSeen  = 0;
    doneEdge  = -1;
    stalls    = 0;
    lastStall = 1'b0;
    lastData  = 8'h00;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    checkOutput({tag, " busy at start"}, 32'(busy), 32'd1);
    while (e < 700 && !(doneSeen > 0 && e >= doneEdge + 4)) begin
      if (lastStall) begin
        checkOutput({tag, " tx_data hold"}, 32'(tx_data), 32'(lastData));
        checkOutput({tag, " tx_valid hold"}, 32'(tx_valid), 32'd1);
      end
      if (done) begin
        doneSeen++;
        doneEdge = e;
      end
      if (doneSeen > 0 && e == doneEdge + 1) begin
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
        checkOutput({tag, " reg_num after done"}, 32'(reg_num), 32'd0);
      end
      ready = (mode == 1) ? (e % 2 == 0) : 1'b1;
      start = (mode == 2 && e == 33);
      if (mode == 3 && e == 20) rf[3] = 32'hDEAD_BEEF;
      if (tx_valid && ready) begin
        if (nb < 128) checkOutput($sformatf("%s byte%0d", tag, nb), 32'(tx_data), 32'(expBytes[nb]));
        nb++;
      end
      if (tx_valid && !ready) stalls++;
      lastStall = tx_valid && !ready;
      lastData  = tx_data;
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
    ready = 1'b1;
    rf[3] = savedR3;
    checkOutput({tag, " byte count"}, 32'(nb), 32'd128);
    checkOutput({tag, " done pulses"}, 32'(doneSeen), 32'd1);
    checkOutput({tag, " done cycle"}, 32'(doneEdge + 1), 32'(193 + stalls));
    if (mode == 1) checkOutput({tag, " stalls nonzero"}, 32'(stalls > 0), 32'd1);
  endtask

  task automatic resetScenario();
    int doneCount;
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (106) @(posedge clk);
    #1;
    checkOutput("rst pre reg_num", 32'(reg_num), 32'd17);
    checkOutput("rst pre tx_data", 32'(tx_data), 32'h22);
    checkOutput("rst pre tx_valid", 32'(tx_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("async rst");
    @(posedge clk); #1;
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) doneCount++;
      @(posedge clk); #1;
    end
    checkOutput("rst no done", 32'(doneCount), 32'd0);
    checkOutput("rst idle busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int n = 0; n < 32; n++) rf[n] = 32'h1122_0000 + 32'(n);

    //              start halted ready busy valid done reg chk data
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h22};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h22};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 8'h11};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, 8'h01};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].halted, vecs[i].ready);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d reg_num", i), 32'(reg_num), 32'(vecs[i].expReg));
      if (vecs[i].chkData)
        checkOutput($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].expData));
    end

    // Abort the table's dump mid-SEND; reset must act between clock edges.
    #2 rst = 1'b1;
    #1;
    checkAllZero("table rst");
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;

    runDump(0);
    runDump(1);
    runDump(2);
    runDump(3);
    resetScenario();
    runDump(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
